uart_tx_shifter: RTL and testbench

//  Serializer stage directly downstream of uart_control_transmitter.
//  - Accepts one parallel character per valid/ready handshake.
//  - Drives the UART TX line: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
//  - Bit timing comes from an internal baud divider. Reports busy and a one-cycle completion pulse back to control.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_baud_gen.sv | 47 ++++
 rtl/uart_tx_shifter.sv | 189 ++++++++++++++++++
 tb/tb_uart_tx_shifter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the UART transmit path.
//   tx_state_t     : serializer FSM encoding (IDLE, START, DATA, PARITY, STOP)
//   calc_baud_div  : clock cycles per UART bit, truncated integer division
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_PARITY = 3'd3,
      TX_STOP   = 3'd4
   } tx_state_t;

   // A zero baud rate yields 0, which the top rejects at elaboration.
   function automatic int calc_baud_div(input int clk_hz, input int baud);
      if (baud <= 0) begin
         return 0;
      end
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Free-running bit-period counter, 0..DIV-1, wrapping only at terminal count.
// Ports:
//   clk_i    in   system clock
//   reset_i  in   synchronous active-high reset (count -> 0)
//   clr_i    in   hold/restart the count at 0
//   tick_o   out  high while the count equals DIV-1 (last cycle of a bit)
//   cnt_o    out  current count
// -----------------------------------------------------------------------------
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int DIV = 10,
   localparam int CW = (DIV < 2) ? 1 : $clog2(DIV)
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          clr_i,
   output logic          tick_o,
   output logic [CW-1:0] cnt_o
);

   localparam logic [CW-1:0] TERM = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clr_i || (cnt_q == TERM)) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = (cnt_q == TERM);
   assign cnt_o  = cnt_q;

endmodule

// File: rtl/uart_tx_shifter.sv
// -----------------------------------------------------------------------------
// uart_tx_shifter
// Serializes one parallel character per valid/ready handshake onto the UART
// TX line: start bit, DATA_BITS data bits LSB first, optional parity bit,
// STOP_BITS stop bits. Every bit lasts DIV = CLK_FREQ_HZ/BAUD_RATE cycles.
//
// Handshake: a character is accepted on a rising edge where tx_valid and
// tx_ready are both high. tx_ready is high only in IDLE and never during
// reset; data and parity_odd are captured at that edge and nothing on the
// inputs affects the frame afterwards.
//
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit
// (^data ^ parity_odd) after the data bits. Without it, parity_odd is unused.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset, aborts any frame
//   tx_data      in   character, sampled on accept
//   tx_valid     in   control has a character
//   tx_ready     out  shifter can accept (IDLE and not in reset)
//   parity_odd   in   1 = odd parity, 0 = even; sampled on accept
//   tx_serial    out  UART line, registered, idle high
//   tx_busy      out  high from the cycle after accept through the last stop cycle
//   tx_done      out  one-cycle pulse on the final cycle of the last stop bit
//   dbg_state_o  out  current FSM state for observation
// -----------------------------------------------------------------------------
module uart_tx_shifter
   import uart_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int BAUD_RATE   = 115_200,
   parameter int DATA_BITS   = 8,
   parameter int STOP_BITS   = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   input  logic                 parity_odd,
   output logic                 tx_serial,
   output logic                 tx_busy,
   output logic                 tx_done,
   output tx_state_t            dbg_state_o
);

   localparam int DIV = calc_baud_div(CLK_FREQ_HZ, BAUD_RATE);
   localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
   localparam int BW  = $clog2(DATA_BITS);

   localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
   localparam logic [CW-1:0] PRE_TERM  = CW'(DIV - 2);

   if (DIV < 2) begin : g_bad_div
      $error("uart_tx_shifter: baud divider must be at least 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_shifter: DATA_BITS must be 5..9");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_shifter: STOP_BITS must be 1 or 2");
   end

   tx_state_t            state_q;
   logic [DATA_BITS-1:0] shreg_q;
   logic [BW-1:0]        bit_q;
   logic                 serial_q;
   logic                 done_q;

`ifdef UART_TX_PARITY_EN
   logic                 par_q;
`else
   logic                 unused_parity_odd;
   assign unused_parity_odd = parity_odd;
`endif

   logic          baud_clr;
   logic          baud_tick;
   logic [CW-1:0] baud_cnt;

   // Holding the divider cleared in IDLE makes the first START cycle count 0,
   // so every bit, including the start bit, lasts exactly DIV cycles.
   assign baud_clr = (state_q == TX_IDLE);

   uart_baud_gen #(
      .DIV (DIV)
   ) u_baud_gen (
      .clk_i   (clk),
      .reset_i (reset),
      .clr_i   (baud_clr),
      .tick_o  (baud_tick),
      .cnt_o   (baud_cnt)
   );

   assign tx_ready    = (state_q == TX_IDLE) && !reset;
   assign tx_busy     = (state_q != TX_IDLE);
   assign tx_serial   = serial_q;
   assign tx_done     = done_q;
   assign dbg_state_o = state_q;

   // The line value for the next bit is loaded on the same edge the state
   // advances, so tx_serial comes straight from a flop with no decode glitches.
   // bit_q counts data bits in DATA and stop bits in STOP.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= TX_IDLE;
         shreg_q  <= '0;
         bit_q    <= '0;
         serial_q <= 1'b1;
         done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q    <= 1'b0;
`endif
      end else begin
         // Registered one cycle early: set on the second-to-last cycle of
         // the last stop bit so the pulse lands on its final cycle.
         done_q <= (state_q == TX_STOP) && (bit_q == LAST_STOP) &&
                   (baud_cnt == PRE_TERM);

         case (state_q)
            TX_IDLE: begin
               if (tx_valid && tx_ready) begin
                  shreg_q  <= tx_data;
                  bit_q    <= '0;
                  serial_q <= 1'b0;
                  state_q  <= TX_START;
`ifdef UART_TX_PARITY_EN
                  par_q    <= (^tx_data) ^ parity_odd;
`endif
               end
            end

            TX_START: begin
               if (baud_tick) begin
                  serial_q <= shreg_q[0];
                  state_q  <= TX_DATA;
               end
            end

            TX_DATA: begin
               if (baud_tick) begin
                  if (bit_q == LAST_DATA) begin
                     bit_q <= '0;
`ifdef UART_TX_PARITY_EN
                     serial_q <= par_q;
                     state_q  <= TX_PARITY;
`else
                     serial_q <= 1'b1;
                     state_q  <= TX_STOP;
`endif
                  end else begin
                     // shreg_q[0] is on the line now; [1] is the next bit.
                     bit_q    <= bit_q + 1'b1;
                     shreg_q  <= shreg_q >> 1;
                     serial_q <= shreg_q[1];
                  end
               end
            end

`ifdef UART_TX_PARITY_EN
            TX_PARITY: begin
               if (baud_tick) begin
                  serial_q <= 1'b1;
                  state_q  <= TX_STOP;
               end
            end
`endif

            TX_STOP: begin
               if (baud_tick) begin
                  if (bit_q == LAST_STOP) begin
                     bit_q   <= '0;
                     state_q <= TX_IDLE;
                  end else begin
                     bit_q <= bit_q + 1'b1;
                  end
               end
            end

            default: begin
               state_q  <= TX_IDLE;
               serial_q <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_shifter.sv
module tb_uart_tx_shifter;
   import uart_pkg::*;

   localparam int DIV = 10;
   localparam int DB  = 8;
`ifdef UART_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   // Accept-to-accept distance for back-to-back frames (one stop bit).
   localparam int B2B_GAP = (1 + DB + P + 1) * DIV + 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   // ---------------- DUTs ----------------
   logic [7:0] tx_data = 8'h00;
   logic       parity_odd = 1'b0;
   logic       valid_a = 1'b0, valid_b = 1'b0;
   logic       ready_a, ser_a, busy_a, done_a;
   logic       ready_b, ser_b, busy_b, done_b;
   tx_state_t  dbg_a, dbg_b;

   uart_tx_shifter #(
      .CLK_FREQ_HZ (50_000_000),
      .BAUD_RATE   (5_000_000),
      .DATA_BITS   (8),
      .STOP_BITS   (1)
   ) u_dut_a (
      .clk (clk), .reset (reset), .tx_data (tx_data), .tx_valid (valid_a),
      .tx_ready (ready_a), .parity_odd (parity_odd), .tx_serial (ser_a),
      .tx_busy (busy_a), .tx_done (done_a), .dbg_state_o (dbg_a)
   );

   uart_tx_shifter #(
      .CLK_FREQ_HZ (50_000_000),
      .BAUD_RATE   (5_000_000),
      .DATA_BITS   (8),
      .STOP_BITS   (2)
   ) u_dut_b (
      .clk (clk), .reset (reset), .tx_data (tx_data), .tx_valid (valid_b),
      .tx_ready (ready_b), .parity_odd (parity_odd), .tx_serial (ser_b),
      .tx_busy (busy_b), .tx_done (done_b), .dbg_state_o (dbg_b)
   );

   // sel picks which instance the frame task drives and observes.
   logic sel = 1'b0;
   logic ready_m, ser_m, busy_m, done_m;
   always_comb begin
      ready_m = sel ? ready_b : ready_a;
      ser_m   = sel ? ser_b   : ser_a;
      busy_m  = sel ? busy_b  : busy_a;
      done_m  = sel ? done_b  : done_a;
   end

   // ---------------- checking ----------------
   int checks = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic set_valid(input logic v);
      if (sel) valid_b = v;
      else     valid_a = v;
   endtask

   // Sends d and checks the line every cycle of the frame.
   // mode 0: drop valid after accept
   // mode 1: keep valid high (next call presents the next character)
   // mode 2: drive 0xFF with valid high during the frame, drop at the end
   task automatic run_frame(input logic [7:0] d, input logic par_odd,
                            input logic exp_par, input int mode,
                            output int done_at);
      logic exp_bits[$];
      int   nstop;
      int   w;
      logic last;
      nstop = sel ? 2 : 1;
      exp_bits.push_back(1'b0);
      for (int i = 0; i < DB; i++) exp_bits.push_back(d[i]);
      if (P == 1) exp_bits.push_back(exp_par);
      for (int s = 0; s < nstop; s++) exp_bits.push_back(1'b1);

      tx_data    = d;
      parity_odd = par_odd;
      set_valid(1'b1);
      w = 0;
      while (!ready_m && w < 300) begin
         @(negedge clk);
         w++;
      end
      check_eq("ready_before_accept", 32'(ready_m), 32'd1);

      @(negedge clk);  // first cycle after the accepting edge
      if (mode == 0) set_valid(1'b0);
      if (mode == 2) tx_data = 8'hFF;

      done_at = -1;
      for (int b = 0; b < exp_bits.size(); b++) begin
         for (int j = 0; j < DIV; j++) begin
            last = (b == exp_bits.size() - 1) && (j == DIV - 1);
            check_eq("serial", 32'(ser_m), 32'(exp_bits[b]));
            check_eq("busy", 32'(busy_m), 32'd1);
            check_eq("ready_in_frame", 32'(ready_m), 32'd0);
            check_eq("done", 32'(done_m), 32'(last));
            if (done_m) done_at = cyc;
            @(negedge clk);
         end
      end
      // The cycle after tx_done: back in IDLE, line high.
      check_eq("ready_after_frame", 32'(ready_m), 32'd1);
      check_eq("busy_after_frame", 32'(busy_m), 32'd0);
      check_eq("serial_idle", 32'(ser_m), 32'd1);
      check_eq("done_after_frame", 32'(done_m), 32'd0);
      if (mode == 2) set_valid(1'b0);
   endtask

   // ---------------- stimulus ----------------
   int t1, t2, t_dummy;

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check_eq("rst_serial_a", 32'(ser_a), 32'd1);
      check_eq("rst_busy_a", 32'(busy_a), 32'd0);
      check_eq("rst_done_a", 32'(done_a), 32'd0);
      check_eq("rst_ready_a", 32'(ready_a), 32'd0);
      check_eq("rst_ready_b", 32'(ready_b), 32'd0);
      check_eq("rst_state_a", 32'(dbg_a), 32'(TX_IDLE));
      reset = 1'b0;
      #1;
      check_eq("ready_after_rst_a", 32'(ready_a), 32'd1);
      check_eq("ready_after_rst_b", 32'(ready_b), 32'd1);
      @(negedge clk);

      // 1. 0xA5, no parity bits set (4 ones): even parity bit 0
      sel = 1'b0;
      run_frame(8'hA5, 1'b0, 1'b0, 0, t_dummy);
      repeat (2) @(negedge clk);

      // 2. Back-to-back with valid held: 0x00 then 0xFF
      run_frame(8'h00, 1'b0, 1'b0, 1, t1);
      run_frame(8'hFF, 1'b0, 1'b0, 0, t2);
      check_eq("b2b_done_gap", 32'(t2 - t1), 32'(B2B_GAP));
      repeat (3) @(negedge clk);

      // 3. 0x07 (3 ones): even -> 1, odd -> 0
      run_frame(8'h07, 1'b0, 1'b1, 0, t_dummy);
      @(negedge clk);
      run_frame(8'h07, 1'b1, 1'b0, 0, t_dummy);
      @(negedge clk);

      // 6. 0x5A accepted, then 0xFF presented with valid during the frame
      run_frame(8'h5A, 1'b0, 1'b0, 2, t_dummy);
      @(negedge clk);
      check_eq("no_accept_after_garbage", 32'(busy_a), 32'd0);

      // 4. Reset mid-frame at N+35
      tx_data = 8'hA5;
      valid_a = 1'b1;
      check_eq("ready_pre_reset_frame", 32'(ready_a), 32'd1);
      @(negedge clk);  // N+1
      valid_a = 1'b0;
      repeat (34) @(negedge clk);  // N+35, data bit 2 of 0xA5
      check_eq("mid_data_busy", 32'(busy_a), 32'd1);
      check_eq("mid_data_serial", 32'(ser_a), 32'd1);
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_eq("abort_serial", 32'(ser_a), 32'd1);
         check_eq("abort_busy", 32'(busy_a), 32'd0);
         check_eq("abort_done", 32'(done_a), 32'd0);
         check_eq("abort_ready", 32'(ready_a), 32'd0);
      end
      reset = 1'b0;
      #1;
      check_eq("ready_after_abort", 32'(ready_a), 32'd1);
      @(negedge clk);
      check_eq("idle_after_abort", 32'(busy_a), 32'd0);
      // Fresh frame after abort: nothing of the old character survives.
      run_frame(8'h81, 1'b0, 1'b0, 0, t_dummy);

      // 5. Two stop bits, 0x3C
      sel = 1'b1;
      @(negedge clk);
      run_frame(8'h3C, 1'b0, 1'b0, 0, t_dummy);
      check_eq("two_stop_a_idle", 32'(busy_a), 32'd0);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
